// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared types and helpers for the FIFO sequencer.
//   state_t  - status FSM encoding (empty / partially filled / full)
//   status_t - registered status flag bundle
//   ptr_w()  - pointer width: RAM address width plus one wrap bit
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic af;
    logic ae;
  } status_t;

  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit FIFO pointer.
//   clk_i, n_rst_i - clock, async active-low reset (pointer -> 0)
//   inc_i          - advance by one on this edge
//   ptr_o          - ADDR_WIDTH+1 bits; MSB is the wrap bit, low bits are the RAM address
// DEPTH is a power of two, so plain binary increment wraps the address field
// DEPTH-1 -> 0 and toggles the wrap bit at the same time.
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         n_rst_i,
  input  logic                         inc_i,
  output logic [ptr_w(ADDR_WIDTH)-1:0] ptr_o
);

  localparam int PW = ptr_w(ADDR_WIDTH);

  logic [PW-1:0] ptr_q, ptr_d;

  assign ptr_d = inc_i ? ptr_q + PW'(1) : ptr_q;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequencer for a synchronous FIFO on a simple dual-port RAM
// (write port A, registered read port B). Data bypasses this block.
//   clk_i, n_rst_i              - clock, async active-low reset
//   wr_valid_i / wr_ready_o     - producer handshake (wr_ready_o = !full_o)
//   rd_req_i / rd_valid_o       - consumer request; rd_valid_o one cycle after accept
//   ram_we_o, ram_waddr_o       - RAM write port controls
//   ram_re_o, ram_raddr_o       - RAM read port controls
//   count_o                     - occupancy 0..DEPTH
//   full_o, empty_o             - occupancy == DEPTH / == 0
//   almost_full_o/_empty_o      - count_o >= AF_THRESH / <= AE_THRESH
//   overflow_o, underflow_o     - sticky error flags, only with FIFO_CTRL_ERR_FLAGS_EN
// Optional feature macro: FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic                  rd_req_i,
  output logic                  rd_valid_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic                  ram_re_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  output logic                  overflow_o,
  output logic                  underflow_o,
`endif
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int PW = ptr_w(ADDR_WIDTH);

  state_t        state_q, state_d;
  status_t       stat_q, stat_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          rd_valid_q;
  logic          wr_acc, rd_acc;

  // Acceptance uses the flags registered at the start of the cycle.
  assign wr_acc = wr_valid_i & ~stat_q.full;
  assign rd_acc = rd_req_i & ~stat_q.empty;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk_i  (clk_i),
    .n_rst_i(n_rst_i),
    .inc_i  (wr_acc),
    .ptr_o  (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk_i  (clk_i),
    .n_rst_i(n_rst_i),
    .inc_i  (rd_acc),
    .ptr_o  (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= ST_EMPTY;
      stat_q     <= '{full: 1'b0, empty: 1'b1, af: 1'b0, ae: 1'b1};
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY:   if (wr_acc) state_d = ST_PARTIAL;
      ST_PARTIAL: begin
        if (rd_acc && !wr_acc && count_q == PW'(1))
          state_d = ST_EMPTY;
        else if (wr_acc && !rd_acc && count_q == PW'(DEPTH - 1))
          state_d = ST_FULL;
      end
      ST_FULL:    if (rd_acc) state_d = ST_PARTIAL;
      default:    state_d = ST_EMPTY;
    endcase
  end

  // Output logic: flags are registered copies of the next state / next count
  always_comb begin
    stat_d       = '0;
    stat_d.full  = (state_d == ST_FULL);
    stat_d.empty = (state_d == ST_EMPTY);
    stat_d.af    = (count_d >= PW'(AF_THRESH));
    stat_d.ae    = (count_d <= PW'(AE_THRESH));
  end

  assign wr_ready_o     = ~stat_q.full;
  assign rd_valid_o     = rd_valid_q;
  assign ram_we_o       = wr_acc;
  assign ram_re_o       = rd_acc;
  assign ram_waddr_o    = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_raddr_o    = rd_ptr[ADDR_WIDTH-1:0];
  assign count_o        = count_q;
  assign full_o         = stat_q.full;
  assign empty_o        = stat_q.empty;
  assign almost_full_o  = stat_q.af;
  assign almost_empty_o = stat_q.ae;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (wr_valid_i & stat_q.full);
      underflow_q <= underflow_q | (rd_req_i & stat_q.empty);
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

  // Occupancy must always equal the wrap-bit pointer distance.
  always @(posedge clk_i) begin
    if (n_rst_i) assert (count_q == PW'(wr_ptr - rd_ptr));
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk_i = 1'b0;
  logic          n_rst_i;
  logic          wr_valid_i, rd_req_i;
  logic          wr_ready_o, rd_valid_o;
  logic          ram_we_o, ram_re_o;
  logic [AW-1:0] ram_waddr_o, ram_raddr_o;
  logic [AW:0]   count_o;
  logic          full_o, empty_o, almost_full_o, almost_empty_o;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic          overflow_o, underflow_o;
`endif

  logic [7:0]    wr_data, rd_data;
  logic [7:0]    mem [DEPTH];

  always #5 clk_i = ~clk_i;

  fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .n_rst_i       (n_rst_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .rd_req_i      (rd_req_i),
    .rd_valid_o    (rd_valid_o),
    .ram_we_o      (ram_we_o),
    .ram_waddr_o   (ram_waddr_o),
    .ram_re_o      (ram_re_o),
    .ram_raddr_o   (ram_raddr_o),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
`endif
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o)
  );

  // Simple dual-port RAM with registered read port
  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_waddr_o] <= wr_data;
    if (ram_re_o) rd_data <= mem[ram_raddr_o];
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_count = 0;
  int         m_wp = 0;
  int         m_rp = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_flags();
    check("count", 32'(count_o), m_count);
    check("full", full_o, m_count == DEPTH);
    check("empty", empty_o, m_count == 0);
    check("almost_full", almost_full_o, m_count >= DEPTH - 2);
    check("almost_empty", almost_empty_o, m_count <= 2);
  endtask

  // One clock: drive, check combinational accept, clock, check registered results.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr);
    logic wa, ra;
    logic [7:0] exp_d;
    @(negedge clk_i);
    wr_valid_i = wv;
    wr_data    = wd;
    rd_req_i   = rr;
    #1;
    wa = wv && (m_count != DEPTH);
    ra = rr && (m_count != 0);
    check("wr_ready", wr_ready_o, m_count != DEPTH);
    check("ram_we", ram_we_o, wa);
    check("ram_re", ram_re_o, ra);
    if (wa) begin
      check("waddr", ram_waddr_o, m_wp);
      sb.push_back(wd);
    end
    if (ra) check("raddr", ram_raddr_o, m_rp);
    @(posedge clk_i);
    #1;
    if (wa) begin m_wp = (m_wp + 1) % DEPTH; m_count++; end
    if (ra) begin m_rp = (m_rp + 1) % DEPTH; m_count--; end
    check("rd_valid", rd_valid_o, ra);
    if (rd_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rd_data: observed=%0d expected=<none, scoreboard empty>", rd_data);
      end else begin
        exp_d = sb.pop_front();
        check("rd_data", rd_data, exp_d);
      end
    end
    check_flags();
  endtask

  initial begin
    n_rst_i    = 1'b0;
    wr_valid_i = 1'b0;
    rd_req_i   = 1'b0;
    wr_data    = '0;
    repeat (2) @(posedge clk_i);
    #1;
    // 1. reset then idle
    check("rst_rd_valid", rd_valid_o, 1'b0);
    check("rst_wr_ready", wr_ready_o, 1'b1);
    check_flags();
    @(negedge clk_i);
    n_rst_i = 1'b1;
    repeat (2) step(1'b0, 8'd0, 1'b0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    check("idle_overflow", overflow_o, 1'b0);
    check("idle_underflow", underflow_o, 1'b0);
`endif

    // 2. fill, then one rejected write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    check("overflow_set", overflow_o, 1'b1);
`endif

    // 3. drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'd0, 1'b1);

    // 4. steady state at count 8 with pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 8'(100 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(120 + i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'd0, 1'b1);

    // 5. simultaneous access when empty, then when full
    step(1'b1, 8'd200, 1'b1);
    step(1'b0, 8'd0, 1'b1);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    check("underflow_set", underflow_o, 1'b1);
`endif
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(50 + i), 1'b0);
    step(1'b1, 8'd99, 1'b1);
    check("full_simul_count", 32'(count_o), 32'd15);

    // 6. async reset mid-stream at count 5
    for (int i = 0; i < 10; i++) step(1'b0, 8'd0, 1'b1);
    check("pre_rst_count", 32'(count_o), 32'd5);
    @(negedge clk_i);
    #2;
    n_rst_i = 1'b0;
    #1;
    m_count = 0; m_wp = 0; m_rp = 0;
    sb.delete();
    check("midrst_rd_valid", rd_valid_o, 1'b0);
    check("midrst_wr_ready", wr_ready_o, 1'b1);
    check_flags();
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    check("midrst_overflow", overflow_o, 1'b0);
    check("midrst_underflow", underflow_o, 1'b0);
`endif
    wr_valid_i = 1'b0;
    rd_req_i   = 1'b0;
    @(negedge clk_i);
    n_rst_i = 1'b1;
    step(1'b1, 8'd77, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
